// File: rtl/dpe_pkg.sv
// dpe_pkg: shared constants, FSM state type and round-robin helper for the DPE ingress arbiter
package dpe_pkg;
   localparam int DEF_NUM_SRC = 5;
   localparam int SRC_CPU  = 0;
   localparam int SRC_ETH1 = 1;
   localparam int SRC_ETH2 = 2;
   localparam int SRC_ETH3 = 3;
   localparam int SRC_ETH4 = 4;
   typedef enum logic {IDLE, PASS} state_t;
   function automatic logic [2:0] rr_idx(input logic [2:0] base, input int k, input int n);
      return 3'((int'(base) + k) % n);
   endfunction
endpackage

// File: rtl/dpe_ingress_arb_if.sv
// dpe_ingress_arb_if: ingress AXI-Stream sources, merged egress stream and status of the arbiter
interface dpe_ingress_arb_if #(
   parameter int DATA_W  = 64,
   parameter int NUM_SRC = 5
);
   logic [NUM_SRC*DATA_W-1:0]   s_tdata;
   logic [NUM_SRC*DATA_W/8-1:0] s_tkeep;
   logic [NUM_SRC-1:0]          s_tvalid;
   logic [NUM_SRC-1:0]          s_tlast;
   logic [NUM_SRC-1:0]          s_tready;
   logic [DATA_W-1:0]           m_tdata;
   logic [DATA_W/8-1:0]         m_tkeep;
   logic                        m_tvalid;
   logic                        m_tlast;
   logic [2:0]                  m_tuser;
   logic                        m_tready;
   logic                        pause;
   logic                        is_idle;
   logic [15:0]                 frm_cnt;
   modport master (
      output s_tdata, s_tkeep, s_tvalid, s_tlast, m_tready, pause,
      input  s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast, m_tuser, is_idle, frm_cnt
   );
   modport slave (
      input  s_tdata, s_tkeep, s_tvalid, s_tlast, m_tready, pause,
      output s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast, m_tuser, is_idle, frm_cnt
   );
endinterface

// File: rtl/dpe_skid_buf.sv
// dpe_skid_buf: two-entry registered skid buffer, full throughput with a fully registered output
module dpe_skid_buf #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              empty
);
   logic              live;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   // live keeps ready low while reset is held so no source handshakes during reset
   assign in_ready = live && !skid_valid;
   assign empty    = !out_valid && !skid_valid;
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         live       <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else begin
         live <= 1'b1;
         if (out_ready || !out_valid) begin
            out_valid  <= skid_valid || (in_valid && in_ready);
            out_data   <= skid_valid ? skid_data : in_data;
            skid_valid <= 1'b0;
         end else if (in_valid && in_ready) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
         end
      end
   end
endmodule

// File: rtl/dpe_ingress_arb.sv
// dpe_ingress_arb: frame-atomic round-robin merge of NUM_SRC AXI-Stream ingress ports into one DPE stream
module dpe_ingress_arb
   import dpe_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int NUM_SRC = DEF_NUM_SRC
) (
   input logic              clk,
   input logic              arst_n,
   dpe_ingress_arb_if.slave bus
);
   localparam int KW = DATA_W / 8;
   localparam int SW = DATA_W + KW + 4;
   state_t        state;
   logic [2:0]    last_grant, cur, win, sel;
   logic          win_ok, grant_vld, in_valid, in_ready, fire, skid_empty;
   logic [SW-1:0] m_bus;
   always_comb begin
      win    = '0;
      win_ok = 1'b0;
      for (int k = 1; k <= NUM_SRC; k++)
         if (!win_ok && bus.s_tvalid[rr_idx(last_grant, k, NUM_SRC)]) begin
            win_ok = 1'b1;
            win    = rr_idx(last_grant, k, NUM_SRC);
         end
   end
   // IDLE grants combinationally so the winner's first beat can go in the decision cycle
   assign sel          = state == PASS ? cur : win;
   assign grant_vld    = state == PASS || (win_ok && !bus.pause);
   assign in_valid     = grant_vld && bus.s_tvalid[sel];
   assign fire         = in_valid && in_ready;
   assign bus.s_tready = grant_vld && in_ready ? NUM_SRC'(1) << sel : '0;
   assign bus.is_idle  = state == IDLE && skid_empty;
   assign {bus.m_tuser, bus.m_tlast, bus.m_tkeep, bus.m_tdata} = m_bus;
   dpe_skid_buf #(.DATA_W(SW)) u_skid (
      .clk       (clk),
      .arst_n    (arst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({sel, bus.s_tlast[sel], bus.s_tkeep[sel*KW +: KW], bus.s_tdata[sel*DATA_W +: DATA_W]}),
      .out_valid (bus.m_tvalid),
      .out_ready (bus.m_tready),
      .out_data  (m_bus),
      .empty     (skid_empty)
   );
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state       <= IDLE;
         last_grant  <= 3'(NUM_SRC - 1);
         cur         <= '0;
         bus.frm_cnt <= '0;
      end else begin
         if (state == IDLE && grant_vld) begin
            cur        <= win;
            last_grant <= win;
         end
         // a single-beat frame taken in the grant cycle never leaves IDLE
         state <= fire && bus.s_tlast[sel] ? IDLE : (grant_vld ? PASS : state);
         if (bus.m_tvalid && bus.m_tready && bus.m_tlast)
            bus.frm_cnt <= bus.frm_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_dpe_ingress_arb.sv
// tb_dpe_ingress_arb: directed scoreboard bench for the DPE ingress arbiter
module tb_dpe_ingress_arb;
   localparam int DW = 64;
   localparam int NS = 5;
   localparam int KW = DW / 8;
   localparam int BW = DW + KW + 4;
   typedef logic [BW-1:0] beat_t;
   logic clk = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;
   dpe_ingress_arb_if #(.DATA_W(DW), .NUM_SRC(NS)) bus ();
   dpe_ingress_arb #(.DATA_W(DW), .NUM_SRC(NS)) dut (.clk(clk), .arst_n(arst_n), .bus(bus));
   beat_t src_q[NS][$];
   beat_t exp_q[$];
   int compared = 0;
   int mismatched = 0;
   logic stall_mode = 1'b0;
   logic chk_no3 = 1'b0;
   logic [15:0] lfsr = 16'hACE1;
   task automatic chk(input string name, input beat_t act, input beat_t exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic timeout(input string name, input int left);
      compared++;
      mismatched++;
      $display("FAIL %s timeout: %0d outstanding, expected 0", name, left);
   endtask
   // beat = {tuser, tlast, tkeep, tdata}; tkeep of beat 0 from source 0 is zero
   function automatic beat_t mk(input int s, input int f, input int b, input bit last);
      return {3'(s), last, 4'(s), 4'(b), 64'(s * 65536 + f * 256 + b)};
   endfunction
   task automatic load(input int s, input int f, input int n);
      for (int b = 0; b < n; b++) src_q[s].push_back(mk(s, f, b, b == n - 1));
   endtask
   task automatic expect_frame(input int s, input int f, input int n);
      for (int b = 0; b < n; b++) exp_q.push_back(mk(s, f, b, b == n - 1));
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask
   task automatic wait_exp(input string name, input int lvl, input int budget);
      int n = 0;
      while (exp_q.size() > lvl && n < budget) begin
         cyc(1);
         n++;
      end
      if (exp_q.size() > lvl) begin
         timeout(name, exp_q.size() - lvl);
         exp_q.delete();
      end
      cyc(2);
   endtask
   task automatic wait_src(input string name, input int s, input int lvl, input int budget);
      int n = 0;
      while (src_q[s].size() > lvl && n < budget) begin
         cyc(1);
         n++;
      end
      if (src_q[s].size() > lvl) timeout(name, src_q[s].size() - lvl);
   endtask
   initial begin
      logic [NS-1:0] hs;
      beat_t b;
      bus.s_tdata = '0;
      bus.s_tkeep = '0;
      bus.s_tvalid = '0;
      bus.s_tlast = '0;
      bus.m_tready = 1'b1;
      bus.pause = 1'b0;
      forever begin
         @(negedge clk);
         hs = bus.s_tvalid & bus.s_tready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NS; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            b = src_q[i].size() > 0 ? src_q[i][0] : '0;
            bus.s_tvalid[i] = src_q[i].size() > 0;
            bus.s_tlast[i] = b[DW+KW];
            bus.s_tkeep[i*KW +: KW] = b[DW+KW-1:DW];
            bus.s_tdata[i*DW +: DW] = b[DW-1:0];
         end
         bus.m_tready = stall_mode ? lfsr[0] : 1'b1;
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end
   initial begin
      beat_t cur, prev;
      logic prev_stall;
      prev = '0;
      prev_stall = 1'b0;
      forever begin
         @(negedge clk);
         cur = {bus.m_tuser, bus.m_tlast, bus.m_tkeep, bus.m_tdata};
         if (!arst_n) prev_stall = 1'b0;
         else begin
            if (prev_stall) begin
               chk("hold_valid", BW'(bus.m_tvalid), BW'(1));
               chk("hold_beat", cur, prev);
            end
            if (bus.m_tvalid && bus.m_tready) begin
               if (exp_q.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("FAIL unexpected_beat: got %h expected none", cur);
               end else chk("beat", cur, exp_q.pop_front());
            end
            if (chk_no3 && bus.s_tvalid[3] && src_q[2].size() > 0)
               chk("rdy3_during_src2", BW'(bus.s_tready[3]), BW'(0));
            prev_stall = bus.m_tvalid && !bus.m_tready;
            prev = cur;
         end
      end
   end
   initial begin
      // all sources valid while reset is held: nothing may be accepted
      load(0, 0, 2); load(1, 0, 2); load(2, 0, 2); load(3, 0, 2); load(4, 0, 2); load(0, 1, 2);
      expect_frame(0, 0, 2); expect_frame(1, 0, 2); expect_frame(2, 0, 2);
      expect_frame(3, 0, 2); expect_frame(4, 0, 2); expect_frame(0, 1, 2);
      cyc(3);
      chk("rst_tready", BW'(bus.s_tready), BW'(0));
      chk("rst_tvalid", BW'(bus.m_tvalid), BW'(0));
      chk("rst_idle", BW'(bus.is_idle), BW'(1));
      chk("rst_frm", BW'(bus.frm_cnt), BW'(0));
      chk("rst_out", {bus.m_tuser, bus.m_tlast, bus.m_tkeep, bus.m_tdata}, BW'(0));
      arst_n = 1'b1;
      wait_exp("rr_all", 0, 200);
      chk("rr_frm", BW'(bus.frm_cnt), BW'(6));
      chk("rr_idle", BW'(bus.is_idle), BW'(1));
      // source 3 arrives while source 2 is mid-frame
      load(2, 1, 8);
      expect_frame(2, 1, 8); expect_frame(3, 1, 2);
      wait_src("src2_beat2", 2, 6, 50);
      chk_no3 = 1'b1;
      load(3, 1, 2);
      wait_exp("atomic", 0, 100);
      chk_no3 = 1'b0;
      chk("atomic_frm", BW'(bus.frm_cnt), BW'(8));
      // random backpressure over a 16-beat frame
      stall_mode = 1'b1;
      load(4, 1, 16);
      expect_frame(4, 1, 16);
      wait_exp("stall", 0, 400);
      stall_mode = 1'b0;
      cyc(2);
      chk("stall_frm", BW'(bus.frm_cnt), BW'(9));
      // pause after source 1 has started; source 0 must wait for pause release
      load(1, 1, 4);
      expect_frame(1, 1, 4); expect_frame(0, 2, 1);
      wait_src("src1_start", 1, 3, 50);
      bus.pause = 1'b1;
      load(0, 2, 1);
      wait_exp("pause_frame", 1, 100);
      cyc(5);
      chk("pause_tready", BW'(bus.s_tready), BW'(0));
      chk("pause_tvalid", BW'(bus.m_tvalid), BW'(0));
      chk("pause_idle", BW'(bus.is_idle), BW'(1));
      chk("pause_frm", BW'(bus.frm_cnt), BW'(10));
      bus.pause = 1'b0;
      wait_exp("pause_release", 0, 100);
      chk("pause_rel_frm", BW'(bus.frm_cnt), BW'(11));
      // asynchronous reset in the middle of a source 2 frame
      load(2, 2, 6);
      expect_frame(2, 2, 6);
      wait_src("src2_mid", 2, 3, 50);
      arst_n = 1'b0;
      #1;
      chk("arst_tready", BW'(bus.s_tready), BW'(0));
      chk("arst_tvalid", BW'(bus.m_tvalid), BW'(0));
      chk("arst_idle", BW'(bus.is_idle), BW'(1));
      chk("arst_frm", BW'(bus.frm_cnt), BW'(0));
      chk("arst_out", {bus.m_tuser, bus.m_tlast, bus.m_tkeep, bus.m_tdata}, BW'(0));
      exp_q.delete();
      for (int i = 0; i < NS; i++) src_q[i].delete();
      load(1, 3, 1); load(0, 3, 1);
      expect_frame(0, 3, 1); expect_frame(1, 3, 1);
      cyc(2);
      arst_n = 1'b1;
      wait_exp("post_rst", 0, 50);
      chk("post_rst_frm", BW'(bus.frm_cnt), BW'(2));
      // frame counter wrap
      arst_n = 1'b0;
      cyc(1);
      arst_n = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         load(0, i, 1);
         expect_frame(0, i, 1);
      end
      wait_exp("wrap_fill", 0, 70000);
      chk("wrap_ffff", BW'(bus.frm_cnt), BW'(16'hFFFF));
      load(0, 7, 1);
      expect_frame(0, 7, 1);
      wait_exp("wrap_last", 0, 50);
      chk("wrap_zero", BW'(bus.frm_cnt), BW'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
